// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for the single-port byte-lane data RAM: M0 (CPU MEM stage) normally wins,
// M1 (DMA/debug) is forced through after MAX_WAIT consecutive denials. Read data is steered back by owner.
module data_ram_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m0_stall,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [7:0]  wait_cnt_reg;
    logic        rd_pend_reg;
    logic        rd_owner_reg;
    logic        force_m1;
    logic [1:0]  gnt_vec;
    logic [1:0]  we_vec;
    logic [1:0]  rvalid_vec;
    logic [31:0] rdata_vec [2];
    logic [31:0] rdata_hold_reg [2];

    assign force_m1   = m1_req & (wait_cnt_reg == WAIT_LIMIT);
    assign gnt_vec[0] = m0_req & ~force_m1;
    assign gnt_vec[1] = m1_req & (force_m1 | ~m0_req);
    assign we_vec     = {m1_we, m0_we};

    assign m0_gnt    = gnt_vec[0];
    assign m1_gnt    = gnt_vec[1];
    assign m0_stall  = m0_req & ~gnt_vec[0];
    assign m0_rvalid = rvalid_vec[0];
    assign m1_rvalid = rvalid_vec[1];
    assign m0_rdata  = rdata_vec[0];
    assign m1_rdata  = rdata_vec[1];

    // Idle bus is driven to all zeros so the RAM sees no stray address/data toggling.
    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_sel   = '0;
        ram_wdata = '0;
        if (gnt_vec[0]) begin
            ram_ce    = 1'b1;
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_sel   = m0_sel;
            ram_wdata = m0_wdata;
        end else if (gnt_vec[1]) begin
            ram_ce    = 1'b1;
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_sel   = m1_sel;
            ram_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !m1_req || gnt_vec[1]) begin
            wait_cnt_reg <= '0;
        end else if (wait_cnt_reg != WAIT_LIMIT) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
    end

    // Pending-read tracker; a new granted read in the return cycle simply re-arms it.
    always_ff @(posedge clk) begin
        if (rst || RD_LAT != 1) begin
            rd_pend_reg  <= 1'b0;
            rd_owner_reg <= 1'b0;
        end else if (|(gnt_vec & ~we_vec)) begin
            rd_pend_reg  <= 1'b1;
            rd_owner_reg <= gnt_vec[1];
        end else begin
            rd_pend_reg  <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign rvalid_vec[gi] = (RD_LAT == 1)
                                  ? (rd_pend_reg & (rd_owner_reg == 1'(gi)))
                                  : (gnt_vec[gi] & ~we_vec[gi]);

            // Each master keeps its last returned word while the other one is being served.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_hold_reg[gi] <= '0;
                end else if (rvalid_vec[gi]) begin
                    rdata_hold_reg[gi] <= ram_rdata;
                end
            end

            assign rdata_vec[gi] = rvalid_vec[gi] ? ram_rdata : rdata_hold_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: scripted vector table, reset-in-flight sequence, randomized traffic
// against a transaction-level model, and a second RD_LAT=0 instance for same-cycle read return.
module tb_data_ram_arbiter;

    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m0_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;

    data_ram_arbiter #(.RD_LAT(1), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m0_stall(m0_stall),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Second instance with combinational-read RAM.
    logic        n_m0_req, n_m0_we, n_m1_req, n_m1_we;
    logic [31:0] n_m0_addr, n_m0_wdata, n_m1_addr, n_m1_wdata;
    logic [3:0]  n_m0_sel, n_m1_sel;
    logic        n_m0_gnt, n_m0_rvalid, n_m1_gnt, n_m1_rvalid, n_m0_stall;
    logic [31:0] n_m0_rdata, n_m1_rdata;
    logic        n_ram_ce, n_ram_we;
    logic [31:0] n_ram_addr, n_ram_wdata, n_ram_rdata;
    logic [3:0]  n_ram_sel;

    data_ram_arbiter #(.RD_LAT(0), .MAX_WAIT(2)) dut0 (
        .clk(clk), .rst(rst),
        .m0_req(n_m0_req), .m0_we(n_m0_we), .m0_addr(n_m0_addr), .m0_sel(n_m0_sel), .m0_wdata(n_m0_wdata),
        .m0_gnt(n_m0_gnt), .m0_rvalid(n_m0_rvalid), .m0_rdata(n_m0_rdata),
        .m1_req(n_m1_req), .m1_we(n_m1_we), .m1_addr(n_m1_addr), .m1_sel(n_m1_sel), .m1_wdata(n_m1_wdata),
        .m1_gnt(n_m1_gnt), .m1_rvalid(n_m1_rvalid), .m1_rdata(n_m1_rdata),
        .m0_stall(n_m0_stall),
        .ram_ce(n_ram_ce), .ram_we(n_ram_we), .ram_addr(n_ram_addr), .ram_sel(n_ram_sel),
        .ram_wdata(n_ram_wdata), .ram_rdata(n_ram_rdata)
    );

    // Byte-lane RAMs: registered read for dut, combinational read for dut0.
    logic [31:0] mem  [256];
    logic [31:0] mem2 [256];

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[9:2]];
            end
        end
    end

    always @(posedge clk) begin
        if (n_ram_ce && n_ram_we)
            for (int b = 0; b < 4; b++)
                if (n_ram_sel[b]) mem2[n_ram_addr[9:2]][b*8 +: 8] <= n_ram_wdata[b*8 +: 8];
    end
    assign n_ram_rdata = mem2[n_ram_addr[9:2]];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: memory image, denial streak, one outstanding read slot.
    logic [31:0] mem_model [256];
    int          streak;
    logic        pend, powner;
    logic [31:0] pdata, last0, last1;
    logic        exp_g0, exp_g1;

    task automatic model_step();
        logic        f, rv0, rv1, we;
        logic [31:0] a, d;
        logic [3:0]  s;
        f      = m1_req && (streak >= MAX_WAIT);
        exp_g0 = m0_req && !f;
        exp_g1 = m1_req && (f || !m0_req);
        rv0    = pend && !powner;
        rv1    = pend && powner;
        we = 1'b0; a = '0; s = '0; d = '0;
        if (exp_g0)      begin we = m0_we; a = m0_addr; s = m0_sel; d = m0_wdata; end
        else if (exp_g1) begin we = m1_we; a = m1_addr; s = m1_sel; d = m1_wdata; end
        chk("m0_gnt", m0_gnt, exp_g0);
        chk("m1_gnt", m1_gnt, exp_g1);
        chk("m0_stall", m0_stall, m0_req && !exp_g0);
        chk("ram_ce", ram_ce, exp_g0 || exp_g1);
        chk("ram_we", ram_we, we);
        chk("ram_addr", ram_addr, a);
        chk("ram_sel", ram_sel, s);
        chk("ram_wdata", ram_wdata, d);
        chk("m0_rvalid", m0_rvalid, rv0);
        chk("m1_rvalid", m1_rvalid, rv1);
        chk("m0_rdata", m0_rdata, rv0 ? pdata : last0);
        chk("m1_rdata", m1_rdata, rv1 ? pdata : last1);
        if (rst) begin
            streak = 0; pend = 0; last0 = '0; last1 = '0;
        end else begin
            if (rv0) last0 = pdata;
            if (rv1) last1 = pdata;
            pend = 1'b0;
            if (exp_g0 || exp_g1) begin
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mem_model[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
                end else begin
                    pend = 1'b1; powner = exp_g1; pdata = mem_model[a[9:2]];
                end
            end
            streak = (m1_req && !exp_g1) ? ((streak + 1 > MAX_WAIT) ? MAX_WAIT : streak + 1) : 0;
        end
    endtask

    typedef struct {
        logic        r0, w0; logic [31:0] a0; logic [3:0] s0; logic [31:0] d0;
        logic        r1, w1; logic [31:0] a1; logic [3:0] s1; logic [31:0] d1;
        logic        g0, g1, st, rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, w0, input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
        input logic r1, w1, input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
        input logic g0, g1, st, rv0, rv1, input logic [31:0] rd0, rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.s0 = s0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.s1 = s1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.st = st; v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic drive(input logic r0, w0, input logic [31:0] a0, input logic [3:0] s0,
                         input logic [31:0] d0, input logic r1, w1, input logic [31:0] a1,
                         input logic [3:0] s1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_sel = s0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_sel = s1; m1_wdata = d1;
    endtask

    task automatic ndrive(input logic r0, w0, input logic [31:0] a0, input logic r1, w1,
                          input logic [31:0] a1, input logic [31:0] d1);
        n_m0_req = r0; n_m0_we = w0; n_m0_addr = a0; n_m0_sel = 4'hF; n_m0_wdata = '0;
        n_m1_req = r1; n_m1_we = w1; n_m1_addr = a1; n_m1_sel = 4'hF; n_m1_wdata = d1;
    endtask

    vec_t vt [24];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA500_0000 | i; mem2[i] = 32'hA500_0000 | i;
        end
        mem[4] = 32'hDEADBEEF; mem2[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;
        for (int i = 0; i < 256; i++) mem_model[i] = mem[i];

        vt[0]  = mk(1,0,'h10,'hF,0,            0,0,0,0,0,                 1,0,0, 0,0, 0,0);
        vt[1]  = mk(0,0,0,0,0,                  0,0,0,0,0,                 0,0,0, 1,0, 'hDEADBEEF,0);
        vt[2]  = mk(0,0,0,0,0,                  1,1,'h20,'h2,'h0000AB00,   0,1,0, 0,0, 0,0);
        vt[3]  = mk(0,0,0,0,0,                  1,0,'h20,'hF,0,            0,1,0, 0,0, 0,0);
        vt[4]  = mk(0,0,0,0,0,                  0,0,0,0,0,                 0,0,0, 0,1, 0,'h1122AB44);
        vt[5]  = mk(1,0,'h10,'hF,0,            1,0,'h20,'hF,0,            1,0,0, 0,0, 0,0);
        vt[6]  = mk(1,0,'h10,'hF,0,            1,0,'h20,'hF,0,            1,0,0, 1,0, 'hDEADBEEF,0);
        vt[7]  = vt[6];
        vt[8]  = vt[6];
        vt[9]  = mk(1,0,'h10,'hF,0,            1,0,'h20,'hF,0,            0,1,1, 1,0, 'hDEADBEEF,0);
        vt[10] = mk(1,0,'h10,'hF,0,            1,0,'h20,'hF,0,            1,0,0, 0,1, 0,'h1122AB44);
        vt[11] = vt[6];
        vt[12] = vt[6];
        vt[13] = vt[6];
        vt[14] = vt[9];
        vt[15] = mk(1,0,'h10,'hF,0,            0,0,0,0,0,                 1,0,0, 0,1, 0,'h1122AB44);
        vt[16] = mk(0,0,0,0,0,                  0,0,0,0,0,                 0,0,0, 1,0, 'hDEADBEEF,0);
        vt[17] = mk(1,1,'h30,'hF,'hAAAAAAAA,   1,1,'h30,'hF,'h55555555,   1,0,0, 0,0, 0,0);
        vt[18] = mk(0,0,0,0,0,                  1,1,'h30,'hF,'h55555555,   0,1,0, 0,0, 0,0);
        vt[19] = mk(1,0,'h30,'hF,0,            0,0,0,0,0,                 1,0,0, 0,0, 0,0);
        vt[20] = mk(0,0,0,0,0,                  0,0,0,0,0,                 0,0,0, 1,0, 'h55555555,0);
        vt[21] = mk(1,1,'h10,'h0,'hFFFFFFFF,   0,0,0,0,0,                 1,0,0, 0,0, 0,0);
        vt[22] = mk(1,0,'h10,'hF,0,            0,0,0,0,0,                 1,0,0, 0,0, 0,0);
        vt[23] = mk(0,0,0,0,0,                  0,0,0,0,0,                 0,0,0, 1,0, 'hDEADBEEF,0);

        rst = 1'b1;
        drive(0,0,0,0,0, 0,0,0,0,0);
        ndrive(0,0,0, 0,0,0,0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        streak = 0; pend = 1'b0; powner = 1'b0; pdata = '0; last0 = '0; last1 = '0;

        #2;
        chk("reset m0_rvalid", m0_rvalid, 0);
        chk("reset m1_rvalid", m1_rvalid, 0);
        chk("reset m0_rdata", m0_rdata, 0);
        chk("reset m1_rdata", m1_rdata, 0);
        chk("idle ram_ce", ram_ce, 0);
        $display("[TB] reset state checked");
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].s0, vt[i].d0,
                  vt[i].r1, vt[i].w1, vt[i].a1, vt[i].s1, vt[i].d1);
            #2;
            chk($sformatf("vec%0d m0_gnt", i), m0_gnt, vt[i].g0);
            chk($sformatf("vec%0d m1_gnt", i), m1_gnt, vt[i].g1);
            chk($sformatf("vec%0d m0_stall", i), m0_stall, vt[i].st);
            chk($sformatf("vec%0d m0_rvalid", i), m0_rvalid, vt[i].rv0);
            chk($sformatf("vec%0d m1_rvalid", i), m1_rvalid, vt[i].rv1);
            if (vt[i].rv0) chk($sformatf("vec%0d m0_rdata", i), m0_rdata, vt[i].rd0);
            if (vt[i].rv1) chk($sformatf("vec%0d m1_rdata", i), m1_rdata, vt[i].rd1);
            $display("[TB] vec %0d: m0_req=%0b m1_req=%0b gnt=%0b%0b rvalid=%0b%0b",
                     i, m0_req, m1_req, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid);
            model_step();
            @(negedge clk);
        end

        // Reset while an M0 read is granted and M1 has accumulated denials.
        for (int i = 0; i < 10; i++) begin
            drive(1,0,'h10,'hF,0, 1,0,'h20,'hF,0);
            rst = (i == 3);
            #2;
            if (i == 4) begin
                chk("post-reset m0_rvalid", m0_rvalid, 0);
                chk("post-reset m1_gnt", m1_gnt, 0);
            end
            if (i == 8) chk("post-reset forced m1_gnt", m1_gnt, 1);
            model_step();
            @(negedge clk);
        end
        rst = 1'b0;
        $display("[TB] reset-during-read sequence done");

        // Randomized traffic; a request is held unchanged until granted.
        drive(0,0,0,0,0, 0,0,0,0,0);
        exp_g0 = 1'b0; exp_g1 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!m0_req || exp_g0) begin
                m0_req = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom_range(0, 1));
                m0_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                m0_sel = 4'($urandom); m0_wdata = $urandom;
            end
            if (!m1_req || exp_g1) begin
                m1_req = ($urandom_range(0, 2) != 0); m1_we = 1'($urandom_range(0, 1));
                m1_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                m1_sel = 4'($urandom); m1_wdata = $urandom;
            end
            #2;
            model_step();
            @(negedge clk);
        end
        drive(0,0,0,0,0, 0,0,0,0,0);
        $display("[TB] random traffic done");

        // RD_LAT=0 instance: idle bus, then same-cycle read return.
        ndrive(0,0,0, 0,0,0,0);
        #2;
        chk("lat0 idle ram_ce", n_ram_ce, 0);
        chk("lat0 idle gnt", {n_m1_gnt, n_m0_gnt}, 0);
        chk("lat0 idle rvalid", {n_m1_rvalid, n_m0_rvalid}, 0);
        $display("[TB] lat0 idle");
        @(negedge clk);
        ndrive(1,0,'h10, 0,0,0,0);
        #2;
        chk("lat0 m0_gnt", n_m0_gnt, 1);
        chk("lat0 m0_rvalid", n_m0_rvalid, 1);
        chk("lat0 m0_rdata", n_m0_rdata, 32'hDEADBEEF);
        chk("lat0 m1_rvalid", n_m1_rvalid, 0);
        $display("[TB] lat0 m0 read 0x10 -> %h", n_m0_rdata);
        @(negedge clk);
        ndrive(0,0,0, 1,1,'h40,'h12345678);
        #2;
        chk("lat0 write m1_gnt", n_m1_gnt, 1);
        chk("lat0 write m1_rvalid", n_m1_rvalid, 0);
        $display("[TB] lat0 m1 write 0x40");
        @(negedge clk);
        ndrive(0,0,0, 1,0,'h40,0);
        #2;
        chk("lat0 m1_rvalid", n_m1_rvalid, 1);
        chk("lat0 m1_rdata", n_m1_rdata, 32'h12345678);
        $display("[TB] lat0 m1 read 0x40 -> %h", n_m1_rdata);
        @(negedge clk);
        ndrive(1,0,'h10, 1,0,'h40,0);
        #2;
        chk("lat0 both m0_rvalid", n_m0_rvalid, 1);
        chk("lat0 both m1_rvalid", n_m1_rvalid, 0);
        chk("lat0 both m0_stall", n_m0_stall, 0);
        $display("[TB] lat0 contention read");
        @(negedge clk);
        ndrive(0,0,0, 0,0,0,0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port, byte-lane data RAM between two masters: M0 = CPU MEM stage (normal priority winner), M1 = secondary master (DMA/debug loader).
- Arbitrates one access per cycle, drives RAM ce/we/addr/sel/data, and returns read data to the owning master, tracking RAM read latency.
- Applies starvation protection so M1 is guaranteed service under continuous M0 traffic.
- Sits between the MEM stage/DMA and data_ram in the SoC top.

Parameters:
- RD_LAT, 1, RAM read latency in cycles. Legal values 0 or 1; must match the RAM's registered-output setting.
- MAX_WAIT, 4, consecutive cycles M1 may be denied before it is forced to win. Legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  M0 access request.
- m0_we  in  1  M0 write (1) / read (0).
- m0_addr  in  32  M0 byte address (`DataAddrBus`).
- m0_sel  in  4  M0 byte-lane enables.
- m0_wdata  in  32  M0 write data (`DataBus`).
- m0_gnt  out  1  M0 request accepted this cycle.
- m0_rvalid  out  1  M0 read data valid.
- m0_rdata  out  32  M0 read data.
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as M0 for M1.
- m0_stall  out  1  CPU stall request = m0_req & ~m0_gnt.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_sel  out  4  RAM byte-lane enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Reset values (rst=1 at clk edge):
  - wait_cnt=0, rd_pend=0, rd_owner=0.
  - m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0.
  - All in-flight reads are discarded; no rvalid is produced after reset.
- Grant (combinational, same cycle as req):
  - If m1_req and wait_cnt==MAX_WAIT: grant M1.
  - Else if m0_req: grant M0.
  - Else if m1_req: grant M1.
  - At most one gnt is high per cycle.
  - Requester must hold req/we/addr/sel/wdata stable until gnt. The transfer completes on the clk edge where gnt=1.
- RAM drive:
  - While a grant is active: ram_ce=1, and ram_we/addr/sel/wdata are muxed from the granted master.
  - No grant: ram_ce=0, ram_we=0, and addr/sel/wdata are all zero.
- Starvation counter (8-bit wait_cnt):
  - +1 on each cycle with m1_req & ~m1_gnt, saturating at MAX_WAIT.
  - Cleared on m1_gnt, or when m1_req=0.
- Writes:
  - A write is acknowledged by gnt alone; it never produces rvalid.
  - sel=4'b0000 write is still granted and consumes the slot; the RAM changes nothing.
- Reads, RD_LAT=1:
  - On a granted read, set rd_pend=1 and rd_owner=granted master at the edge.
  - Next cycle, ram_rdata is routed to the owner: mX_rvalid=1 and mX_rdata=ram_rdata, combinational from rd_pend/rd_owner.
  - The other master's rvalid=0 and rdata holds its last value.
  - rd_pend clears unless another read is granted in that cycle; back-to-back reads sustain 1 per cycle.
  - A read granted while a previous read's data is returning is legal; the owner updates at the edge.
- Reads, RD_LAT=0:
  - mX_rvalid = mX_gnt & ~mX_we in the same cycle.
  - mX_rdata = ram_rdata.
  - No pending state is used.
- Read-after-write to the same address in consecutive cycles returns the new data. No bypass is needed because the RAM writes at the edge.
- m0_stall is high exactly when M0 requests and loses. It does not cover read latency; the pipeline uses m0_rvalid for that.
- Simultaneous M0 and M1 writes to the same address: only the winner writes that cycle; the loser writes in a later cycle, so the loser's data persists.

Test Plan:
- M0-only read, RD_LAT=1: preload word 0x10=0xDEADBEEF; m0 read addr 0x10, sel=F -> m0_gnt in cycle 0; m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 1; m1_rvalid stays 0.
- Byte write: m1 write addr 0x20, sel=4'b0010, wdata=0x0000AB00 over 0x11223344 -> subsequent read returns 0x1122AB44.
- Contention + starvation, MAX_WAIT=4: m0_req held high, m1_req held high from cycle 0 -> M0 granted cycles 0-3; M1 granted cycle 4; wait_cnt returns to 0; m0_stall=1 only in cycle 4; pattern repeats every 5 cycles.
- Back-to-back reads alternating owners: M1 at cycle 0 (forced), M0 at cycle 1 -> m1_rvalid cycle 1 with M1 data, m0_rvalid cycle 2 with M0 data; never both high.
- Reset mid-read: m0 read granted cycle 0, rst=1 at cycle 0 edge -> m0_rvalid=0 in cycle 1; wait_cnt=0; RAM contents unchanged.
- Idle and RD_LAT=0: no requests -> ram_ce=0, all gnt/rvalid 0. With RD_LAT=0, m0 read -> m0_rvalid and m0_rdata in the same cycle as m0_gnt.
